video_frame_ctrl: RTL and testbench

Frame-level controller between the AXI4-Stream video source (16-bit {mask, img} beats, tuser = start of frame, tlast = end of line) and the centre-of-gravity accumulation datapath. It sequences the accumulator: it clears it at every valid frame start, forwards only well-formed pixels tagged with x/y coordinates, and reports frame completion. It detects missing, early or late framing markers and then resynchronises at the next tuser.

---
 rtl/cog_video_pkg.sv | 19 +
 rtl/video_pos_counter.sv | 58 +++++
 rtl/video_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_video_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cog_video_pkg.sv
// Shared types for the centre-of-gravity video front end: error codes and
// frame-controller states.
package cog_video_pkg;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_MISSING_SOF = 3'd1,
        ERR_EARLY_EOL   = 3'd2,
        ERR_LATE_EOL    = 3'd3,
        ERR_UNEXP_SOF   = 3'd4
    } err_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESYNC = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/video_pos_counter.sv
// x/y position of the next expected beat in the current frame, with
// end-of-line and end-of-frame flags decoded from the registered position.
module video_pos_counter
    import cog_video_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          step_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          eol_o,
    output logic          eof_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q, x_d, base_x;
    logic [YW-1:0] y_q, y_d, base_y;

    // clear and step together consume pixel (0,0) in one cycle
    always_comb begin
        base_x = clear_i ? '0 : x_q;
        base_y = clear_i ? '0 : y_q;
        x_d    = base_x;
        y_d    = base_y;
        if (step_i) begin
            if (base_x == X_LAST) begin
                x_d = '0;
                y_d = (base_y == Y_LAST) ? '0 : base_y + 1'b1;
            end else begin
                x_d = base_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign eol_o = (x_q == X_LAST);
    assign eof_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame-level sequencer between the AXI4-Stream video source and the
// centre-of-gravity accumulator; checks framing and resynchronises on tuser.
module video_frame_ctrl
    import cog_video_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic           sys_clk,
    input  logic           sys_areset,
    input  logic           en,
    input  logic [2*N-1:0] s_axis_tdata,
    input  logic           s_axis_tvalid,
    input  logic           s_axis_tlast,
    input  logic           s_axis_tuser,
    output logic           s_axis_tready,
    output logic [N-1:0]   m_pix_img,
    output logic [N-1:0]   m_pix_mask,
    output logic [XW-1:0]  m_pix_x,
    output logic [YW-1:0]  m_pix_y,
    output logic           m_pix_valid,
    output logic           acc_clear,
    output logic           acc_done,
    output logic           frame_err,
    output logic [2:0]     err_code,
    output logic [15:0]    frame_cnt
);

    ctrl_state_t   state_q, state_d;
    logic          tready_q;
    logic [N-1:0]  img_q, img_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic          valid_q, valid_d;
    logic          clear_q, clear_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    err_t          code_q, code_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          pos_clear, pos_step;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          pos_eol, pos_eof;

    video_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_pos (
        .clk_i   (sys_clk),
        .rst_i   (sys_areset),
        .clear_i (pos_clear),
        .step_i  (pos_step),
        .x_o     (pos_x),
        .y_o     (pos_y),
        .eol_o   (pos_eol),
        .eof_o   (pos_eof)
    );

    always_comb begin
        state_d   = state_q;
        pos_clear = 1'b0;
        pos_step  = 1'b0;
        img_d     = img_q;
        mask_d    = mask_q;
        px_d      = px_q;
        py_d      = py_q;
        valid_d   = 1'b0;
        clear_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        cnt_d     = cnt_q;

        if (s_axis_tvalid) begin
            unique case (state_q)
                IDLE, RESYNC: begin
                    if (en && s_axis_tuser) begin
                        pos_clear = 1'b1;
                        pos_step  = 1'b1;
                        valid_d   = 1'b1;
                        clear_d   = 1'b1;
                        img_d     = s_axis_tdata[N-1:0];
                        mask_d    = s_axis_tdata[2*N-1:N];
                        px_d      = '0;
                        py_d      = '0;
                        state_d   = ACTIVE;
                    end else if (en && state_q == IDLE) begin
                        err_d   = 1'b1;
                        code_d  = ERR_MISSING_SOF;
                        state_d = RESYNC;
                    end
                end
                ACTIVE: begin
                    if (s_axis_tuser) begin
                        pos_clear = 1'b1;
                        pos_step  = 1'b1;
                        valid_d   = 1'b1;
                        clear_d   = 1'b1;
                        err_d     = 1'b1;
                        code_d    = ERR_UNEXP_SOF;
                        img_d     = s_axis_tdata[N-1:0];
                        mask_d    = s_axis_tdata[2*N-1:N];
                        px_d      = '0;
                        py_d      = '0;
                    end else if (s_axis_tlast && !pos_eol) begin
                        err_d   = 1'b1;
                        code_d  = ERR_EARLY_EOL;
                        state_d = RESYNC;
                    end else if (pos_eol && !s_axis_tlast) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LATE_EOL;
                        state_d = RESYNC;
                    end else begin
                        pos_step = 1'b1;
                        valid_d  = 1'b1;
                        img_d    = s_axis_tdata[N-1:0];
                        mask_d   = s_axis_tdata[2*N-1:N];
                        px_d     = pos_x;
                        py_d     = pos_y;
                        if (pos_eof) begin
                            done_d  = 1'b1;
                            cnt_d   = cnt_q + 16'd1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_areset) begin
        if (sys_areset) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            img_q    <= '0;
            mask_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
            valid_q  <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= 1'b1;
            img_q    <= img_d;
            mask_q   <= mask_d;
            px_q     <= px_d;
            py_q     <= py_d;
            valid_q  <= valid_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_pix_img     = img_q;
    assign m_pix_mask    = mask_q;
    assign m_pix_x       = px_q;
    assign m_pix_y       = py_q;
    assign m_pix_valid   = valid_q;
    assign acc_clear     = clear_q;
    assign acc_done      = done_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Directed self-checking bench for video_frame_ctrl with a 10x10 frame.
module tb_video_frame_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_areset;
    logic        en;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        s_axis_tready;
    logic [7:0]  m_pix_img;
    logic [7:0]  m_pix_mask;
    logic [3:0]  m_pix_x;
    logic [3:0]  m_pix_y;
    logic        m_pix_valid;
    logic        acc_clear;
    logic        acc_done;
    logic        frame_err;
    logic [2:0]  err_code;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int pix_seen, clr_seen, done_seen, err_seen;
    int exp_cnt  = 0;

    video_frame_ctrl #(
        .N      (8),
        .WIDTH  (10),
        .HEIGHT (10)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_areset    (sys_areset),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_pix_img     (m_pix_img),
        .m_pix_mask    (m_pix_mask),
        .m_pix_x       (m_pix_x),
        .m_pix_y       (m_pix_y),
        .m_pix_valid   (m_pix_valid),
        .acc_clear     (acc_clear),
        .acc_done      (acc_done),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .frame_cnt     (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkdata(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b ^ 8'hA5, b};
    endfunction

    task automatic sample();
        if (m_pix_valid) pix_seen++;
        if (acc_clear)   clr_seen++;
        if (acc_done)    done_seen++;
        if (frame_err)   err_seen++;
    endtask

    task automatic clr_counts();
        pix_seen = 0; clr_seen = 0; done_seen = 0; err_seen = 0;
    endtask

    task automatic beat(input bit u, input bit l, input logic [15:0] d);
        @(negedge sys_clk);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
        @(posedge sys_clk);
        #1;
        sample();
    endtask

    // idle cycles carry junk sideband that must be ignored
    task automatic gap(input int n);
        logic [7:0] held;
        held = m_pix_img;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'($urandom_range(0, 1));
            s_axis_tlast  = 1'($urandom_range(0, 1));
            s_axis_tdata  = 16'($urandom);
            @(posedge sys_clk);
            #1;
            sample();
            chk("gap_valid", m_pix_valid, 0);
            chk("gap_err", frame_err, 0);
            chk("gap_img_hold", m_pix_img, held);
        end
    endtask

    task automatic send_range(input int from, input int to, input int sof_at, input bit gaps);
        for (int k = from; k <= to; k++) begin
            if (gaps) gap($urandom_range(0, 1));
            beat(k == sof_at, (k % 10) == 9, mkdata(k));
        end
    endtask

    task automatic clean_frame(input bit gaps);
        logic [15:0] d;
        clr_counts();
        for (int k = 0; k < 100; k++) begin
            if (gaps) gap($urandom_range(0, 2));
            d = mkdata(k);
            beat(k == 0, (k % 10) == 9, d);
            chk("pix_valid", m_pix_valid, 1);
            chk("pix_x", m_pix_x, k % 10);
            chk("pix_y", m_pix_y, k / 10);
            chk("pix_img", m_pix_img, d[7:0]);
            chk("pix_mask", m_pix_mask, d[15:8]);
            chk("acc_clear", acc_clear, k == 0);
            chk("acc_done", acc_done, k == 99);
            chk("frame_err", frame_err, 0);
        end
        exp_cnt++;
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("frame_pix_count", pix_seen, 100);
        chk("frame_err_count", err_seen, 0);
    endtask

    task automatic chk_zero(input string tag, input bit ready_exp);
        chk({tag, "_img"}, m_pix_img, 0);
        chk({tag, "_mask"}, m_pix_mask, 0);
        chk({tag, "_x"}, m_pix_x, 0);
        chk({tag, "_y"}, m_pix_y, 0);
        chk({tag, "_valid"}, m_pix_valid, 0);
        chk({tag, "_clear"}, acc_clear, 0);
        chk({tag, "_done"}, acc_done, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_tready"}, s_axis_tready, ready_exp);
    endtask

    initial begin
        sys_areset    = 1'b1;
        en            = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        clr_counts();

        // reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero("rst", 1'b0);
        @(negedge sys_clk);
        sys_areset = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("tready_after_release", s_axis_tready, 1);
        chk("valid_after_release", m_pix_valid, 0);

        // clean frame with gaps, then one back-to-back with no dead cycle
        clean_frame(1'b1);
        chk("done_count_a", done_seen, 1);
        clean_frame(1'b0);

        // early tlast at x=2 of line 0
        beat(1'b1, 1'b0, mkdata(0));
        beat(1'b0, 1'b0, mkdata(1));
        beat(1'b0, 1'b1, mkdata(2));
        chk("early_err", frame_err, 1);
        chk("early_code", err_code, 2);
        chk("early_valid", m_pix_valid, 0);
        clr_counts();
        send_range(3, 24, -1, 1'b1);
        chk("early_drop_pix", pix_seen, 0);
        chk("early_drop_err", err_seen, 0);
        clean_frame(1'b1);
        chk("early_code_held", err_code, 2);

        // missing tlast at x=9 of line 0
        send_range(0, 8, 0, 1'b0);
        beat(1'b0, 1'b0, mkdata(9));
        chk("late_err", frame_err, 1);
        chk("late_code", err_code, 3);
        chk("late_valid", m_pix_valid, 0);
        clr_counts();
        send_range(10, 24, -1, 1'b1);
        chk("late_drop_pix", pix_seen, 0);
        chk("late_drop_err", err_seen, 0);
        clean_frame(1'b1);

        // full frame without tuser from IDLE
        clr_counts();
        send_range(0, 99, -1, 1'b1);
        chk("nosof_err_count", err_seen, 1);
        chk("nosof_code", err_code, 1);
        chk("nosof_pix", pix_seen, 0);
        chk("nosof_cnt", frame_cnt, exp_cnt);
        clean_frame(1'b1);

        // unexpected tuser on beat 47 restarts the frame
        send_range(0, 46, 0, 1'b1);
        beat(1'b1, 1'b0, mkdata(47));
        chk("unexp_err", frame_err, 1);
        chk("unexp_code", err_code, 4);
        chk("unexp_clear", acc_clear, 1);
        chk("unexp_valid", m_pix_valid, 1);
        chk("unexp_x", m_pix_x, 0);
        chk("unexp_y", m_pix_y, 0);
        chk("unexp_no_done", acc_done, 0);
        clr_counts();
        send_range(1, 99, -1, 1'b1);
        exp_cnt++;
        chk("unexp_done_count", done_seen, 1);
        chk("unexp_last_done", acc_done, 1);
        chk("unexp_last_x", m_pix_x, 9);
        chk("unexp_last_y", m_pix_y, 9);
        chk("unexp_pix", pix_seen, 99);
        chk("unexp_cnt", frame_cnt, exp_cnt);

        // en dropped mid-frame: frame completes, next frame ignored
        clr_counts();
        send_range(0, 49, 0, 1'b1);
        en = 1'b0;
        send_range(50, 99, -1, 1'b1);
        exp_cnt++;
        chk("en_done_count", done_seen, 1);
        chk("en_cnt", frame_cnt, exp_cnt);
        clr_counts();
        send_range(0, 99, 0, 1'b1);
        chk("en_off_pix", pix_seen, 0);
        chk("en_off_err", err_seen, 0);
        chk("en_off_clear", clr_seen, 0);
        chk("en_off_cnt", frame_cnt, exp_cnt);
        en = 1'b1;

        // asynchronous reset mid-frame
        send_range(0, 30, 0, 1'b0);
        #2;
        sys_areset = 1'b1;
        #1;
        chk_zero("midrst", 1'b0);
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        sys_areset    = 1'b0;
        exp_cnt       = 0;
        @(posedge sys_clk);
        #1;
        chk("midrst_tready", s_axis_tready, 1);
        clean_frame(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
